sm83_bus_resp: RTL and testbench

SM83_BUS_RESP -- requirements
Module: sm83_bus_resp

---
 rtl/sm83_bus_resp_pkg.sv | 14 +
 rtl/sm83_bus_resp_if.sv | 30 +++
 rtl/sm83_bus_resp_strobe_edge.sv | 26 ++
 rtl/sm83_bus_resp.sv | 155 +++++++++++++++
 tb/tb_sm83_bus_resp.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_bus_resp_pkg.sv
// Shared types and default widths for the SM83 bus responder slice.
package sm83_pkg;

  localparam int unsigned SM83_ADR_WIDTH = 16;
  localparam int unsigned SM83_WORD_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    WR     = 2'd2,
    COMMIT = 2'd3
  } sm83_resp_state_t;

endpackage

// File: rtl/sm83_bus_resp_if.sv
// CPU-side bus of the SM83 responder: phases, address, strobes, data.
interface sm83_bus_resp_if
  import sm83_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = SM83_ADR_WIDTH,
  parameter int unsigned WORD_SIZE = SM83_WORD_SIZE
) ();

  logic                 t1;
  logic                 t2;
  logic                 t3;
  logic                 t4;
  logic [ADR_WIDTH-1:0] adr;
  logic                 n_rd;
  logic                 n_wr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rdata_oe;

  modport master (
    output t1, t2, t3, t4, adr, n_rd, n_wr, wdata,
    input  rdata, rdata_oe
  );

  modport slave (
    input  t1, t2, t3, t4, adr, n_rd, n_wr, wdata,
    output rdata, rdata_oe
  );

endinterface

// File: rtl/sm83_bus_resp_strobe_edge.sv
// Active-low strobe qualifier: a strobe only counts once it has been seen
// released after reset, so a strobe held low through reset is ignored.
module sm83_strobe_edge (
  input  logic clk,
  input  logic n_reset,
  input  logic strobe_n_i,
  output logic active_o
);

  logic armed_q;
  logic armed_d;

  // Arm as soon as the strobe is observed high; stays armed until reset.
  always_comb begin
    armed_d = armed_q | strobe_n_i;
  end

  // Arming register; reset disarms.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) armed_q <= 1'b0;
    else          armed_q <= armed_d;
  end

  assign active_o = armed_q & ~strobe_n_i;

endmodule

// File: rtl/sm83_bus_resp.sv
// SM83 register-window bus responder. Decodes an aligned NREG window at
// BASE, turns CPU strobes into one-clk backend read/write pulses and holds
// read data for the CPU until the read strobe rises.
// Optional feature: define SM83_BUS_RESP_WPROT_EN for write protection
// (wprot input, sticky wprot_hit output).
module sm83_bus_resp
  import sm83_pkg::*;
#(
  parameter int unsigned          ADR_WIDTH = SM83_ADR_WIDTH,
  parameter int unsigned          WORD_SIZE = SM83_WORD_SIZE,
  parameter logic [ADR_WIDTH-1:0] BASE      = 16'hff40,
  parameter int unsigned          NREG      = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  sm83_bus_resp_if.slave           bus,
  output logic [$clog2(NREG)-1:0]  reg_adr,
  output logic                     reg_we,
  output logic                     reg_re,
  output logic [WORD_SIZE-1:0]     reg_wdata,
  input  logic [WORD_SIZE-1:0]     reg_rdata,
  output logic                     conflict
`ifdef SM83_BUS_RESP_WPROT_EN
  ,
  input  logic                     wprot,
  output logic                     wprot_hit
`endif
);

  localparam int unsigned IDXW = $clog2(NREG);

  sm83_resp_state_t     state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 oe_q, oe_d;
  logic                 re_q, re_d;
  logic                 conflict_q, conflict_d;
  logic                 rd_act, wr_act;
  logic                 hit;

  sm83_strobe_edge u_rd_edge (
    .clk        (clk),
    .n_reset    (n_reset),
    .strobe_n_i (bus.n_rd),
    .active_o   (rd_act)
  );

  sm83_strobe_edge u_wr_edge (
    .clk        (clk),
    .n_reset    (n_reset),
    .strobe_n_i (bus.n_wr),
    .active_o   (wr_act)
  );

  assign hit = (bus.adr[ADR_WIDTH-1:IDXW] == BASE[ADR_WIDTH-1:IDXW]);

  // Next-state and datapath: only IDLE looks at the address; later states
  // use the index captured on entry. A simultaneous read+write is a write.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    oe_d       = oe_q;
    re_d       = 1'b0;
    conflict_d = conflict_q;
    case (state_q)
      IDLE: begin
        if (hit && wr_act) begin
          state_d = WR;
          idx_d   = bus.adr[IDXW-1:0];
          wdata_d = bus.wdata;
          if (rd_act) conflict_d = 1'b1;
        end else if (hit && rd_act) begin
          state_d = RD;
          idx_d   = bus.adr[IDXW-1:0];
          re_d    = 1'b1;
        end
      end
      RD: begin
        if (bus.n_rd) begin
          state_d = IDLE;
          rdata_d = '0;
          oe_d    = 1'b0;
        end else begin
          if (wr_act) conflict_d = 1'b1;
          if (!oe_q) begin
            rdata_d = reg_rdata;
            oe_d    = 1'b1;
          end
        end
      end
      WR: begin
        if (bus.n_wr) begin
          state_d = COMMIT;
        end else begin
          wdata_d = bus.wdata;
          if (rd_act) conflict_d = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      re_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      re_q       <= re_d;
      conflict_q <= conflict_d;
    end
  end

  assign reg_adr      = idx_q;
  assign reg_re       = re_q;
  assign reg_wdata    = wdata_q;
  assign conflict     = conflict_q;
  assign bus.rdata    = rdata_q;
  assign bus.rdata_oe = oe_q;

`ifdef SM83_BUS_RESP_WPROT_EN
  logic wph_q, wph_d;

  // A protected commit is dropped and remembered until reset.
  always_comb begin
    wph_d = wph_q | ((state_q == COMMIT) && wprot);
  end

  // Sticky write-protect hit flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) wph_q <= 1'b0;
    else          wph_q <= wph_d;
  end

  assign reg_we    = (state_q == COMMIT) && !wprot;
  assign wprot_hit = wph_q;
`else
  assign reg_we = (state_q == COMMIT);
`endif

endmodule

// File: tb/tb_sm83_bus_resp.sv
// Self-checking bench for sm83_bus_resp: directed vector table, hand-written
// reset/conflict sequences and randomized transactions against a memory model.
module tb_sm83_bus_resp;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 16;

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    bit          hit;
    logic [3:0]  idx;
    logic [7:0]  exp_d;
  } vec_t;

  logic       clk;
  logic       n_reset;
  logic [3:0] reg_adr;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       conflict;
`ifdef SM83_BUS_RESP_WPROT_EN
  logic       wprot;
  logic       wprot_hit;
  logic       s_wph;
`endif

  logic [7:0] bk_mem  [16];
  logic [7:0] ref_mem [16];

  int n_cmp = 0;
  int n_bad = 0;
  int ph;
  int re_cnt = 0;
  int we_cnt = 0;
  logic [3:0] last_we_adr;
  logic [7:0] last_we_data;

  logic [7:0] s_rdata;
  logic       s_oe;
  logic [3:0] s_adr;
  logic       s_we;
  logic       s_re;
  logic [7:0] s_wdata;
  logic       s_conf;
  logic [3:0] s_ph;

  sm83_bus_resp_if #(.ADR_WIDTH(AW), .WORD_SIZE(DW)) bus ();

  sm83_bus_resp #(
    .ADR_WIDTH (AW),
    .WORD_SIZE (DW),
    .BASE      (16'hff40),
    .NREG      (NR)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .bus       (bus),
    .reg_adr   (reg_adr),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .conflict  (conflict)
`ifdef SM83_BUS_RESP_WPROT_EN
    ,
    .wprot     (wprot),
    .wprot_hit (wprot_hit)
`endif
  );

  // Backend register file as seen by the DUT.
  assign reg_rdata = bk_mem[reg_adr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic drive_phase();
    bus.t1 = (ph == 0);
    bus.t2 = (ph == 1);
    bus.t3 = (ph == 2);
    bus.t4 = (ph == 3);
  endtask

  // One clock: snapshot outputs at negedge, act as backend, then step phase.
  task automatic tick();
    @(negedge clk);
    s_rdata = bus.rdata;
    s_oe    = bus.rdata_oe;
    s_adr   = reg_adr;
    s_we    = reg_we;
    s_re    = reg_re;
    s_wdata = reg_wdata;
    s_conf  = conflict;
    s_ph    = {bus.t1, bus.t2, bus.t3, bus.t4};
`ifdef SM83_BUS_RESP_WPROT_EN
    s_wph   = wprot_hit;
`endif
    if (reg_re) re_cnt++;
    if (reg_we) begin
      we_cnt++;
      last_we_adr  = reg_adr;
      last_we_data = reg_wdata;
      bk_mem[reg_adr] = reg_wdata;
    end
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    drive_phase();
  endtask

  task automatic wait_t1();
    for (int g = 0; g < 4 && ph != 0; g++) tick();
  endtask

  task automatic do_read(input logic [15:0] a, input bit late, input int hold, input bit jumble,
                         output int nre, output logic oe4, output logic [7:0] rd4,
                         output logic [3:0] adr4, output logic oe_end, output logic [7:0] rd_end);
    int re0;
    wait_t1();
    re0 = re_cnt;
    bus.adr = a;
    if (late) tick();
    bus.n_rd = 1'b0;
    tick();
    if (jumble) bus.adr = 16'($urandom);
    for (int g = 0; g < 8 && !s_ph[0]; g++) tick();
    oe4  = s_oe;
    rd4  = s_rdata;
    adr4 = s_adr;
    repeat (hold) tick();
    bus.n_rd = 1'b1;
    tick();
    tick();
    oe_end = s_oe;
    rd_end = s_rdata;
    nre = re_cnt - re0;
    bus.adr = 16'h0000;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit late, input int hold,
                          input bit chg, input logic [7:0] d2, input bit both,
                          output int nwe, output logic [1:0] we_lat,
                          output logic [3:0] wadr, output logic [7:0] wdat);
    int we0;
    wait_t1();
    we0 = we_cnt;
    bus.adr   = a;
    bus.wdata = d;
    if (late) tick();
    bus.n_wr = 1'b0;
    if (both) bus.n_rd = 1'b0;
    tick();
    if (chg) begin
      bus.wdata = d2;
      bus.adr   = 16'($urandom);
    end
    for (int g = 0; g < 8 && !s_ph[0]; g++) tick();
    repeat (hold) tick();
    bus.n_wr = 1'b1;
    bus.n_rd = 1'b1;
    tick();
    we_lat[1] = s_we;
    tick();
    we_lat[0] = s_we;
    tick();
    nwe  = we_cnt - we0;
    wadr = last_we_adr;
    wdat = last_we_data;
    bus.adr = 16'h0000;
  endtask

  initial begin
    vec_t        vt [7];
    int          nre, nwe, re0, we0;
    logic        oe4, oe_e;
    logic [7:0]  rd4, rd_e, wd, d, d2, expd;
    logic [3:0]  adr4, wa, idx;
    logic [1:0]  wl;
    logic [15:0] a;
    bit          wr, hit, late, chg;
    int          hold;

    vt[0] = '{1'b0, 16'hff43, 8'h5a, 1'b1, 4'd3,  8'h5a};
    vt[1] = '{1'b1, 16'hff4f, 8'hc3, 1'b1, 4'd15, 8'hc3};
    vt[2] = '{1'b0, 16'hff50, 8'h99, 1'b0, 4'd0,  8'h00};
    vt[3] = '{1'b1, 16'hff3f, 8'h77, 1'b0, 4'd0,  8'h00};
    vt[4] = '{1'b1, 16'hff40, 8'h01, 1'b1, 4'd0,  8'h01};
    vt[5] = '{1'b0, 16'hff4f, 8'h3c, 1'b1, 4'd15, 8'h3c};
    vt[6] = '{1'b0, 16'hff48, 8'he7, 1'b1, 4'd8,  8'he7};

    for (int i = 0; i < 16; i++) begin
      bk_mem[i]  = 8'(i * 17) ^ 8'h5a;
      ref_mem[i] = 8'(i * 17) ^ 8'h5a;
    end

    // Reset with a hit read strobe already low.
    ph = 0;
    drive_phase();
    n_reset   = 1'b0;
    bus.adr   = 16'hff43;
    bus.n_rd  = 1'b0;
    bus.n_wr  = 1'b1;
    bus.wdata = 8'h00;
`ifdef SM83_BUS_RESP_WPROT_EN
    wprot = 1'b0;
`endif
    repeat (3) tick();
    check("rst rdata", s_rdata, 0);
    check("rst rdata_oe", s_oe, 0);
    check("rst reg_adr", s_adr, 0);
    check("rst reg_we", s_we, 0);
    check("rst reg_re", s_re, 0);
    check("rst reg_wdata", s_wdata, 0);
    check("rst conflict", s_conf, 0);
`ifdef SM83_BUS_RESP_WPROT_EN
    check("rst wprot_hit", s_wph, 0);
`endif
    n_reset = 1'b1;
    repeat (6) tick();
    check("held strobe re_count", re_cnt, 0);
    check("held strobe rdata_oe", s_oe, 0);
    bus.n_rd = 1'b1;
    tick();
    tick();

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (!vt[i].wr) begin
        bk_mem[vt[i].a[3:0]]  = vt[i].d;
        ref_mem[vt[i].a[3:0]] = vt[i].d;
        do_read(vt[i].a, 1'b0, 1, 1'b0, nre, oe4, rd4, adr4, oe_e, rd_e);
        check($sformatf("tbl%0d re_count", i), nre, vt[i].hit ? 1 : 0);
        check($sformatf("tbl%0d rdata_oe@t4", i), oe4, vt[i].hit);
        check($sformatf("tbl%0d rdata@t4", i), rd4, vt[i].exp_d);
        if (vt[i].hit) check($sformatf("tbl%0d reg_adr", i), adr4, vt[i].idx);
        check($sformatf("tbl%0d rdata after", i), {oe_e, rd_e}, 0);
      end else begin
        do_write(vt[i].a, vt[i].d, 1'b0, 0, 1'b0, 8'h00, 1'b0, nwe, wl, wa, wd);
        check($sformatf("tbl%0d we_count", i), nwe, vt[i].hit ? 1 : 0);
        check($sformatf("tbl%0d we_latency", i), wl, vt[i].hit ? 2'b01 : 2'b00);
        if (vt[i].hit) begin
          check($sformatf("tbl%0d we reg_adr", i), wa, vt[i].idx);
          check($sformatf("tbl%0d we reg_wdata", i), wd, vt[i].exp_d);
          ref_mem[vt[i].idx] = vt[i].exp_d;
        end
      end
    end

    // Long-held read strobe: one backend read only.
    do_read(16'hff45, 1'b1, 9, 1'b0, nre, oe4, rd4, adr4, oe_e, rd_e);
    check("long read re_count", nre, 1);
    check("long read rdata", rd4, ref_mem[5]);

    // Read and write strobes together at a hit address.
    re0 = re_cnt;
    do_write(16'hff41, 8'h11, 1'b0, 0, 1'b0, 8'h00, 1'b1, nwe, wl, wa, wd);
    check("conflict we_count", nwe, 1);
    check("conflict re_count", re_cnt - re0, 0);
    check("conflict reg_adr", wa, 1);
    check("conflict reg_wdata", wd, 8'h11);
    check("conflict flag", s_conf, 1);
    ref_mem[1] = 8'h11;
    do_read(16'hff41, 1'b0, 0, 1'b0, nre, oe4, rd4, adr4, oe_e, rd_e);
    check("conflict readback", rd4, 8'h11);
    check("conflict sticky", s_conf, 1);

    // Reset in the middle of a write.
    wait_t1();
    we0 = we_cnt;
    bus.adr   = 16'hff44;
    bus.wdata = 8'hab;
    bus.n_wr  = 1'b0;
    tick();
    tick();
    n_reset = 1'b0;
    #1;
    check("midwr rst reg_we", reg_we, 0);
    check("midwr rst reg_adr", reg_adr, 0);
    check("midwr rst reg_wdata", reg_wdata, 0);
    check("midwr rst conflict", conflict, 0);
    check("midwr rst rdata", {bus.rdata_oe, bus.rdata}, 0);
    bus.n_wr = 1'b1;
    tick();
    tick();
    n_reset = 1'b1;
    repeat (3) tick();
    check("midwr no commit", we_cnt - we0, 0);
    do_write(16'hff40, 8'h9e, 1'b0, 0, 1'b0, 8'h00, 1'b0, nwe, wl, wa, wd);
    check("post-rst we_count", nwe, 1);
    check("post-rst reg_adr", wa, 0);
    check("post-rst reg_wdata", wd, 8'h9e);
    ref_mem[0] = 8'h9e;

`ifdef SM83_BUS_RESP_WPROT_EN
    wprot = 1'b1;
    do_write(16'hff42, 8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b0, nwe, wl, wa, wd);
    check("wprot we_count", nwe, 0);
    check("wprot_hit", s_wph, 1);
    wprot = 1'b0;
    do_write(16'hff42, 8'h66, 1'b0, 0, 1'b0, 8'h00, 1'b0, nwe, wl, wa, wd);
    check("unprot we_count", nwe, 1);
    check("unprot reg_wdata", wd, 8'h66);
    check("wprot_hit sticky", s_wph, 1);
    ref_mem[2] = 8'h66;
`endif

    // Randomized transactions against the memory model.
    for (int n = 0; n < 40; n++) begin
      wr   = ($urandom_range(0, 1) == 1);
      late = ($urandom_range(0, 1) == 1);
      chg  = ($urandom_range(0, 1) == 1);
      hold = int'($urandom_range(0, 3));
      d    = 8'($urandom);
      d2   = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        a = 16'hff40 + 16'($urandom_range(0, 15));
      end else begin
        a = 16'($urandom);
        if (a[15:4] == 12'hff4) a[4] = ~a[4];
      end
      hit = (a >= 16'hff40) && (a <= 16'hff4f);
      idx = 4'(a - 16'hff40);
      if (!wr) begin
        do_read(a, late, hold, chg, nre, oe4, rd4, adr4, oe_e, rd_e);
        expd = hit ? ref_mem[idx] : 8'h00;
        check($sformatf("rnd%0d rd re_count", n), nre, hit ? 1 : 0);
        check($sformatf("rnd%0d rd oe@t4", n), oe4, hit);
        check($sformatf("rnd%0d rd rdata@t4", n), rd4, expd);
        if (hit) check($sformatf("rnd%0d rd reg_adr", n), adr4, idx);
        check($sformatf("rnd%0d rd idle after", n), {oe_e, rd_e}, 0);
      end else begin
        do_write(a, d, late, hold, chg, d2, 1'b0, nwe, wl, wa, wd);
        expd = chg ? d2 : d;
        check($sformatf("rnd%0d wr we_count", n), nwe, hit ? 1 : 0);
        if (hit) begin
          check($sformatf("rnd%0d wr reg_adr", n), wa, idx);
          check($sformatf("rnd%0d wr reg_wdata", n), wd, expd);
          ref_mem[idx] = expd;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
